// File: rtl/hilo_muldiv_unit.sv
// HI/LO register pair with an iterative signed multiply / multiply-accumulate / divide engine.
// One magnitude bit per cycle in RUN; signs and accumulation are applied in FIN.
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mALUOp,
    input  logic [1:0]       acc_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [1:0]       hiSel,
    input  logic [1:0]       loSel,
    input  logic             hiWr,
    input  logic             loWr,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int W = WIDTH;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] cnt;
    logic [W-1:0]     magA, magB;
    logic             signA, signB, isDiv;
    logic [1:0]       accOp;
    // Shared shift register: upper W+1 bits hold partial product / remainder,
    // lower W bits hold the multiplier / dividend-then-quotient.
    logic [2*W:0]     work;

    logic             launch, divByZero, moveHi, moveLo, finWr;
    logic [W:0]       mulAdd, mulSum, remShift, remNext;
    logic             remGe;
    logic [2*W:0]     mulNext, divNext;
    logic [2*W-1:0]   prodMag, prodSigned, accRes;
    logic [W-1:0]     quoSigned, remSigned, resHi, resLo;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (start) stateNext = divByZero ? FIN : RUN;
            RUN:     if (cnt == CNT_W'(W - 1)) stateNext = FIN;
            FIN:     stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        launch    = (state == IDLE) && start;
        divByZero = mALUOp && (rt_val == '0);
        // A launch in the same cycle takes priority over a move
        moveHi    = (state == IDLE) && !start && hiWr && (hiSel == 2'b01);
        moveLo    = (state == IDLE) && !start && loWr && (loSel == 2'b01);
        finWr     = (state == FIN);
    end

    always_comb begin
        mulAdd   = work[0] ? {1'b0, magA} : '0;
        mulSum   = work[2*W:W] + mulAdd;
        mulNext  = {1'b0, mulSum, work[W-1:1]};

        remShift = {work[2*W-1:W], work[W-1]};
        remGe    = (remShift >= {1'b0, magB});
        remNext  = remGe ? (remShift - {1'b0, magB}) : remShift;
        divNext  = {remNext, work[W-2:0], remGe};
    end

    always_comb begin
        prodMag    = work[2*W-1:0];
        prodSigned = (signA ^ signB) ? -prodMag : prodMag;
        case (accOp)
            2'b01:   accRes = {hi, lo} + prodSigned;
            2'b10:   accRes = {hi, lo} - prodSigned;
            default: accRes = prodSigned;
        endcase
        quoSigned = (signA ^ signB) ? -work[W-1:0] : work[W-1:0];
        remSigned = signA ? -work[2*W-1:W] : work[2*W-1:W];

        // Divide-by-zero parked the raw dividend in the low half at launch
        if (isDiv && div_zero) begin
            resHi = work[W-1:0];
            resLo = '1;
        end else if (isDiv) begin
            resHi = remSigned;
            resLo = quoSigned;
        end else begin
            resHi = accRes[2*W-1:W];
            resLo = accRes[W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
            cnt      <= '0;
            magA     <= '0;
            magB     <= '0;
            signA    <= 1'b0;
            signB    <= 1'b0;
            isDiv    <= 1'b0;
            accOp    <= 2'b00;
            work     <= '0;
        end else begin
            done <= finWr;
            if (launch) begin
                magA     <= rs_val[W-1] ? -rs_val : rs_val;
                magB     <= rt_val[W-1] ? -rt_val : rt_val;
                signA    <= rs_val[W-1];
                signB    <= rt_val[W-1];
                isDiv    <= mALUOp;
                accOp    <= acc_op;
                div_zero <= divByZero;
                cnt      <= '0;
                if (divByZero)
                    work <= {{(W+1){1'b0}}, rs_val};
                else if (mALUOp)
                    work <= {{(W+1){1'b0}}, (rs_val[W-1] ? -rs_val : rs_val)};
                else
                    work <= {{(W+1){1'b0}}, (rt_val[W-1] ? -rt_val : rt_val)};
            end else if (state == RUN) begin
                cnt  <= cnt + 1'b1;
                work <= isDiv ? divNext : mulNext;
            end
            if (finWr) begin
                if (hiSel == 2'b00) hi <= resHi;
                if (loSel == 2'b00) lo <= resLo;
            end
            if (moveHi) hi <= rs_val;
            if (moveLo) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed-vector bench for hilo_muldiv_unit: latency, signed results, accumulate,
// moves, ignored strobes while busy, divide-by-zero and mid-operation reset.
module tb_hilo_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mALUOp, hiWr, loWr;
    logic [1:0]  acc_op, hiSel, loSel;
    logic [31:0] rs_val, rt_val;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int vecs = 0;
    int errs = 0;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mALUOp(mALUOp), .acc_op(acc_op),
        .rs_val(rs_val), .rt_val(rt_val), .hiSel(hiSel), .loSel(loSel),
        .hiWr(hiWr), .loWr(loWr), .hi(hi), .lo(lo), .busy(busy), .done(done),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Caller drives start and operands at a negedge, then calls this.
    task automatic runOp(input string tag, input logic [31:0] expHi, input logic [31:0] expLo,
                         input int expLat, input logic expDz, input int pokeAt);
        logic [31:0] preHi, preLo;
        logic        held, earlyDone;
        int          lat;
        preHi = hi; preLo = lo; held = 1'b1; earlyDone = 1'b0;
        @(negedge clk);
        lat = 1;
        start = 1'b0; hiWr = 1'b0; loWr = 1'b0; hiSel = 2'b00; loSel = 2'b00;
        check({tag, ".busy0"}, 64'(busy), 64'd1);
        check({tag, ".dz0"}, 64'(div_zero), 64'(expDz));
        while (busy && lat < 100) begin
            if (hi !== preHi || lo !== preLo) held = 1'b0;
            if (done) earlyDone = 1'b1;
            if (lat == pokeAt) begin
                start = 1'b1; hiWr = 1'b1; loWr = 1'b1; hiSel = 2'b01; loSel = 2'b01;
                rs_val = 32'hDEADBEEF; rt_val = 32'h7;
            end else if (lat == pokeAt + 1) begin
                start = 1'b0; hiWr = 1'b0; loWr = 1'b0; hiSel = 2'b00; loSel = 2'b00;
            end
            @(negedge clk);
            lat++;
        end
        check({tag, ".lat"}, 64'(lat), 64'(expLat));
        check({tag, ".held"}, 64'(held), 64'd1);
        check({tag, ".early"}, 64'(earlyDone), 64'd0);
        check({tag, ".done"}, 64'(done), 64'd1);
        check({tag, ".hilo"}, {hi, lo}, {expHi, expLo});
        @(negedge clk);
        check({tag, ".done1"}, 64'(done), 64'd0);
    endtask

    task automatic launch(input logic div, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; mALUOp = div; acc_op = op; rs_val = a; rt_val = b;
    endtask

    task automatic move(input logic hw, input logic [1:0] hs, input logic lw,
                        input logic [1:0] ls, input logic [31:0] v);
        hiWr = hw; hiSel = hs; loWr = lw; loSel = ls; rs_val = v;
        @(negedge clk);
        hiWr = 1'b0; loWr = 1'b0; hiSel = 2'b00; loSel = 2'b00;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mALUOp = 1'b0; acc_op = 2'b00;
        rs_val = '0; rt_val = '0; hiSel = 2'b00; loSel = 2'b00; hiWr = 1'b0; loWr = 1'b0;
        #2;
        check("rst.hilo", {hi, lo}, 64'd0);
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        launch(1'b0, 2'b00, 32'hFFFFFFFD, 32'd5);
        runOp("mult_m3x5", 32'hFFFFFFFF, 32'hFFFFFFF1, 34, 1'b0, 0);

        launch(1'b1, 2'b00, 32'd17, 32'hFFFFFFFB);
        runOp("div_17_m5", 32'h00000002, 32'hFFFFFFFD, 34, 1'b0, 0);
        check("div_17_m5.dz", 64'(div_zero), 64'd0);

        launch(1'b1, 2'b00, 32'hFFFFFFEF, 32'd5);
        runOp("div_m17_5", 32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0, 0);

        launch(1'b1, 2'b00, 32'd100, 32'd7);
        runOp("div_100_7", 32'd2, 32'd14, 34, 1'b0, 0);

        launch(1'b1, 2'b00, 32'd7, 32'd0);
        runOp("div_by_0", 32'd7, 32'hFFFFFFFF, 2, 1'b1, 0);
        check("div_by_0.sticky", 64'(div_zero), 64'd1);

        launch(1'b0, 2'b00, 32'd6, 32'd7);
        runOp("mult_6x7", 32'd0, 32'd42, 34, 1'b0, 0);
        check("mult_6x7.dz", 64'(div_zero), 64'd0);

        move(1'b1, 2'b01, 1'b0, 2'b00, 32'h55);
        check("mthi55", {hi, lo}, {32'h55, 32'd42});
        // hiWr with a non-01 select must not write HI
        move(1'b1, 2'b10, 1'b1, 2'b01, 32'd10);
        check("mtlo10", {hi, lo}, {32'h55, 32'd10});
        move(1'b1, 2'b00, 1'b0, 2'b01, 32'd99);
        check("sel00", {hi, lo}, {32'h55, 32'd10});
        move(1'b1, 2'b01, 1'b0, 2'b00, 32'd0);
        check("mthi0", {hi, lo}, {32'd0, 32'd10});

        launch(1'b0, 2'b01, 32'd4, 32'd5);
        runOp("madd_4x5", 32'd0, 32'd30, 34, 1'b0, 0);
        launch(1'b0, 2'b10, 32'd8, 32'd8);
        runOp("msub_8x8", 32'hFFFFFFFF, 32'hFFFFFFDE, 34, 1'b0, 0);

        // start and MTLO in the same cycle: the move is dropped
        launch(1'b0, 2'b00, 32'd2, 32'd3);
        loWr = 1'b1; loSel = 2'b01;
        runOp("start_vs_mv", 32'd0, 32'd6, 34, 1'b0, 0);

        launch(1'b0, 2'b11, 32'hFFFFFFF9, 32'd9);
        runOp("mult_poke", 32'hFFFFFFFF, 32'hFFFFFFC1, 34, 1'b0, 10);

        launch(1'b0, 2'b00, 32'h80000000, 32'h80000000);
        runOp("mult_min", 32'h40000000, 32'd0, 34, 1'b0, 0);

        move(1'b1, 2'b01, 1'b0, 2'b00, 32'h1234);
        check("preload", 64'(hi), 64'h1234);
        launch(1'b0, 2'b00, 32'd3, 32'd3);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check("rst_mid.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid.hilo", {hi, lo}, 64'd0);
        check("rst_mid.busy", 64'(busy), 64'd0);
        check("rst_mid.done", 64'(done), 64'd0);
        repeat (3) @(negedge clk);
        check("rst_mid.done_hold", 64'(done), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        launch(1'b0, 2'b00, 32'd3, 32'd4);
        runOp("after_rst", 32'd0, 32'd12, 34, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
